// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - two-entry ALU result FIFO with condition flags and overflow statistics
module alu_result_buffer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_cout,
    input  logic             in_vout,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf,
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] ovf_count
);

    logic [WIDTH-1:0] result_q [2];
    logic [1:0]       zero_q;
    logic [1:0]       neg_q;
    logic [1:0]       carry_q;
    logic [1:0]       ovf_q;
    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;

    logic push;
    logic pop;
    logic is_arith;
    logic new_carry;
    logic new_ovf;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Only the adder path produces meaningful carry/overflow; logic ops and SLT do not.
    assign is_arith  = (in_op[1:0] == 2'b10);
    assign new_carry = is_arith & in_cout;
    assign new_ovf   = is_arith & in_vout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q[0] <= '0;
            result_q[1] <= '0;
            zero_q      <= '0;
            neg_q       <= '0;
            carry_q     <= '0;
            ovf_q       <= '0;
        end else if (push) begin
            result_q[wr_ptr] <= in_result;
            zero_q[wr_ptr]   <= (in_result == '0);
            neg_q[wr_ptr]    <= in_result[WIDTH-1];
            carry_q[wr_ptr]  <= new_carry;
            ovf_q[wr_ptr]    <= new_ovf;
        end
    end

    // An overflowing push takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end else if (push && new_ovf) begin
            sticky_ovf <= 1'b1;
            if (clr_sticky)
                ovf_count <= CNT_W'(1);
            else if (ovf_count != {CNT_W{1'b1}})
                ovf_count <= ovf_count + CNT_W'(1);
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end
    end

    always_comb begin
        out_result = '0;
        out_zero   = 1'b0;
        out_neg    = 1'b0;
        out_carry  = 1'b0;
        out_ovf    = 1'b0;
        if (out_valid) begin
            out_result = result_q[rd_ptr];
            out_zero   = zero_q[rd_ptr];
            out_neg    = neg_q[rd_ptr];
            out_carry  = carry_q[rd_ptr];
            out_ovf    = ovf_q[rd_ptr];
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - directed self-checking bench for alu_result_buffer
module tb_alu_result_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_cout;
    logic        in_vout;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_neg;
    logic        out_carry;
    logic        out_ovf;
    logic        clr_sticky;
    logic        sticky_ovf;
    logic [7:0]  ovf_count;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_result2;
    logic        out_zero2;
    logic        out_neg2;
    logic        out_carry2;
    logic        out_ovf2;
    logic        sticky_ovf2;
    logic [1:0]  ovf_count2;

    int vectors;
    int miscompares;

    alu_result_buffer #(.WIDTH(32), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_cout(in_cout), .in_vout(in_vout), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry), .out_ovf(out_ovf),
        .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .ovf_count(ovf_count)
    );

    // Narrow-counter instance shares the stimulus so saturation is reachable quickly.
    alu_result_buffer #(.WIDTH(32), .CNT_W(2)) u_dut_narrow (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2), .in_result(in_result),
        .in_cout(in_cout), .in_vout(in_vout), .in_op(in_op),
        .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
        .out_zero(out_zero2), .out_neg(out_neg2), .out_carry(out_carry2), .out_ovf(out_ovf2),
        .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf2), .ovf_count(ovf_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] r,
                         input logic c, input logic o);
        in_valid  = v;
        in_op     = op;
        in_result = r;
        in_cout   = c;
        in_vout   = o;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        out_ready   = 1'b0;
        clr_sticky  = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
        step();
        step();
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_ovf_count", {24'b0, ovf_count}, 32'd0);
        #2 rst_n = 1'b1;
        step();

        // ADD giving zero with carry out
        drive(1'b1, 3'b010, 32'h0, 1'b1, 1'b0);
        step();
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
        check("add_out_valid", {31'b0, out_valid}, 32'd1);
        check("add_zero", {31'b0, out_zero}, 32'd1);
        check("add_carry", {31'b0, out_carry}, 32'd1);
        check("add_ovf", {31'b0, out_ovf}, 32'd0);
        check("add_neg", {31'b0, out_neg}, 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pop_out_valid", {31'b0, out_valid}, 32'd0);
        check("pop_in_ready", {31'b0, in_ready}, 32'd1);

        // SUB overflow, then AND with vout asserted must not count
        drive(1'b1, 3'b110, 32'h8000_0000, 1'b0, 1'b1);
        step();
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
        check("sub_neg", {31'b0, out_neg}, 32'd1);
        check("sub_ovf", {31'b0, out_ovf}, 32'd1);
        check("sub_zero", {31'b0, out_zero}, 32'd0);
        check("sub_sticky", {31'b0, sticky_ovf}, 32'd1);
        check("sub_count", {24'b0, ovf_count}, 32'd1);
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 32'h0000_0005, 1'b1, 1'b1);
        step();
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
        out_ready = 1'b0;
        check("and_result", out_result, 32'h0000_0005);
        check("and_ovf", {31'b0, out_ovf}, 32'd0);
        check("and_carry", {31'b0, out_carry}, 32'd0);
        check("and_count", {24'b0, ovf_count}, 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Back-pressure: A, B fill the buffer, C is held off
        drive(1'b1, 3'b001, 32'hAAAA_0001, 1'b0, 1'b0);
        step();
        drive(1'b1, 3'b001, 32'hBBBB_0002, 1'b0, 1'b0);
        step();
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 3'b001, 32'hCCCC_0003, 1'b0, 1'b0);
        step();
        check("full_head_a", out_result, 32'hAAAA_0001);
        check("full_in_ready_held", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        check("drain_b", out_result, 32'hBBBB_0002);
        check("drain_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
        check("drain_c", out_result, 32'hCCCC_0003);
        step();
        out_ready = 1'b0;
        check("drain_empty", {31'b0, out_valid}, 32'd0);

        // Steady push+pop at count 1 for 10 cycles
        drive(1'b1, 3'b011, 32'h1000_0000, 1'b0, 1'b0);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("stream_valid", {31'b0, out_valid}, 32'd1);
            check("stream_data", out_result, 32'h1000_0000 + 32'(i));
            in_result = 32'h1000_0000 + 32'(i + 1);
            step();
        end
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
        check("stream_last", out_result, 32'h1000_000A);
        step();
        out_ready = 1'b0;
        check("stream_empty", {31'b0, out_valid}, 32'd0);

        // Saturation of the 2-bit counter and clear/push priority
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("clr_count", {24'b0, ovf_count}, 32'd0);
        out_ready = 1'b1;
        drive(1'b1, 3'b010, 32'h7000_0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step();
        check("sat_count_narrow", {30'b0, ovf_count2}, 32'd3);
        check("sat_count_wide", {24'b0, ovf_count}, 32'd5);
        clr_sticky = 1'b1;
        step();
        check("clr_push_sticky", {31'b0, sticky_ovf2}, 32'd1);
        check("clr_push_count", {30'b0, ovf_count2}, 32'd1);
        check("clr_push_count_wide", {24'b0, ovf_count}, 32'd1);
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
        step();
        clr_sticky = 1'b0;
        check("clr_only_sticky", {31'b0, sticky_ovf}, 32'd0);
        check("clr_only_count", {24'b0, ovf_count}, 32'd0);
        out_ready = 1'b0;

        // Asynchronous reset with two entries buffered
        drive(1'b1, 3'b010, 32'h7FFF_FFFF, 1'b0, 1'b1);
        step();
        step();
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
        check("pre_rst_full", {31'b0, in_ready}, 32'd0);
        check("pre_rst_count", {24'b0, ovf_count}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_in_ready", {31'b0, in_ready}, 32'd1);
        check("arst_sticky", {31'b0, sticky_ovf}, 32'd0);
        check("arst_count", {24'b0, ovf_count}, 32'd0);
        check("arst_result", out_result, 32'd0);
        #1 rst_n = 1'b1;
        drive(1'b1, 3'b001, 32'h1234_5678, 1'b0, 1'b0);
        step();
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0);
        check("post_rst_data", out_result, 32'h1234_5678);
        step();
        check("post_rst_hold", out_result, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
